// File: rtl/bexkat_bus_pkg.sv
// Shared types for the bexkat1 two-master Avalon-MM bus arbiter.
// State encoding doubles as the one-hot grant vector (bit0 = s0, bit1 = s1).
package bexkat_bus_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } arb_state_e;

endpackage

// File: rtl/bexkat_rr_grant2.sv
// Registered round-robin grant engine for two requesters with a hold limit
// that bounds back-to-back completions while the other side is waiting.
module bexkat_rr_grant2
  import bexkat_bus_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       slave_wait_i,
  output logic [1:0] grant_o
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  arb_state_e        state_q;
  logic              last_q;
  logic [HOLD_W-1:0] hold_q;

  logic       cur_idx;
  logic       req_cur;
  logic       req_oth;
  logic       hold_expired;
  arb_state_e other_state;

  assign cur_idx      = (state_q == GRANT1);
  assign req_cur      = req_i[cur_idx];
  assign req_oth      = req_i[~cur_idx];
  assign other_state  = cur_idx ? GRANT0 : GRANT1;
  // Compared one bit wider so hold_q + 1 cannot wrap before the test.
  assign hold_expired = ({1'b0, hold_q} + (HOLD_W + 1)'(1)) >= (HOLD_W + 1)'(MAX_HOLD);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      hold_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          hold_q <= '0;
          if (req_i == 2'b11) begin
            state_q <= last_q ? GRANT0 : GRANT1;
          end else if (req_i[0]) begin
            state_q <= GRANT0;
          end else if (req_i[1]) begin
            state_q <= GRANT1;
          end
        end
        GRANT0, GRANT1: begin
          if (req_cur && !slave_wait_i) begin
            if (req_oth && hold_expired) begin
              state_q <= other_state;
              last_q  <= cur_idx;
              hold_q  <= '0;
            end else if (req_oth) begin
              hold_q <= hold_q + HOLD_W'(1);
            end else begin
              hold_q <= '0;
            end
          end else if (!req_cur) begin
            // Holder withdrew; a stalled transfer is otherwise never preempted.
            state_q <= req_oth ? other_state : IDLE;
            last_q  <= cur_idx;
            hold_q  <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          hold_q  <= '0;
        end
      endcase
    end
  end

  assign grant_o = state_q;

endmodule

// File: rtl/bexkat_bus_arbiter.sv
// Two-master (CPU s0, DMA/video s1) to one-slave Avalon-MM arbiter.
// Command muxing and waitrequest gating follow the registered grant.
module bexkat_bus_arbiter
  import bexkat_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_HOLD   = 4
) (
  input  logic                    csi_clk,
  input  logic                    rsi_reset,

  input  logic [ADDR_WIDTH-1:0]   avs_s0_address,
  input  logic                    avs_s0_read,
  input  logic                    avs_s0_write,
  input  logic [DATA_WIDTH-1:0]   avs_s0_writedata,
  input  logic [DATA_WIDTH/8-1:0] avs_s0_byteenable,
  output logic [DATA_WIDTH-1:0]   avs_s0_readdata,
  output logic                    avs_s0_waitrequest,

  input  logic [ADDR_WIDTH-1:0]   avs_s1_address,
  input  logic                    avs_s1_read,
  input  logic                    avs_s1_write,
  input  logic [DATA_WIDTH-1:0]   avs_s1_writedata,
  input  logic [DATA_WIDTH/8-1:0] avs_s1_byteenable,
  output logic [DATA_WIDTH-1:0]   avs_s1_readdata,
  output logic                    avs_s1_waitrequest,

  output logic [ADDR_WIDTH-1:0]   avm_m0_address,
  output logic                    avm_m0_read,
  output logic                    avm_m0_write,
  output logic [DATA_WIDTH-1:0]   avm_m0_writedata,
  output logic [DATA_WIDTH/8-1:0] avm_m0_byteenable,
  input  logic [DATA_WIDTH-1:0]   avm_m0_readdata,
  input  logic                    avm_m0_waitrequest,

  output logic [1:0]              grant
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic [1:0] req;

  assign req = {avs_s1_read | avs_s1_write, avs_s0_read | avs_s0_write};

  bexkat_rr_grant2 #(
    .MAX_HOLD(MAX_HOLD)
  ) u_grant (
    .clk_i       (csi_clk),
    .rst_i       (rsi_reset),
    .req_i       (req),
    .slave_wait_i(avm_m0_waitrequest),
    .grant_o     (grant)
  );

  always_comb begin
    avm_m0_address    = '0;
    avm_m0_read       = 1'b0;
    avm_m0_write      = 1'b0;
    avm_m0_writedata  = '0;
    avm_m0_byteenable = BE_WIDTH'(0);
    case (grant)
      2'b01: begin
        avm_m0_address    = avs_s0_address;
        avm_m0_read       = avs_s0_read;
        avm_m0_write      = avs_s0_write;
        avm_m0_writedata  = avs_s0_writedata;
        avm_m0_byteenable = avs_s0_byteenable;
      end
      2'b10: begin
        avm_m0_address    = avs_s1_address;
        avm_m0_read       = avs_s1_read;
        avm_m0_write      = avs_s1_write;
        avm_m0_writedata  = avs_s1_writedata;
        avm_m0_byteenable = avs_s1_byteenable;
      end
      default: ;
    endcase
  end

  // A master without the grant is always stalled.
  assign avs_s0_waitrequest = grant[0] ? avm_m0_waitrequest : 1'b1;
  assign avs_s1_waitrequest = grant[1] ? avm_m0_waitrequest : 1'b1;

  assign avs_s0_readdata = avm_m0_readdata;
  assign avs_s1_readdata = avm_m0_readdata;

endmodule

// File: tb/tb_bexkat_bus_arbiter.sv
// Self-checking bench for bexkat_bus_arbiter: hand-derived vector table,
// directed corner sequences, then random traffic against an ownership model.
module tb_bexkat_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 16;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] s0_addr, s1_addr, m_addr;
  logic          s0_rd, s0_wr, s1_rd, s1_wr, m_rd, m_wr;
  logic [DW-1:0] s0_wd, s1_wd, m_wd, rd0, rd1, m_rdata;
  logic [1:0]    s0_be, s1_be, m_be, grant;
  logic          w0, w1, m_wait;

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the bus, who was served last, and how many
  // transfers the owner has finished in a row while the other side waited.
  int owner;
  int last_srv;
  int streak;

  bexkat_bus_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MAX_HOLD  (MH)
  ) dut (
    .csi_clk           (clk),
    .rsi_reset         (rst),
    .avs_s0_address    (s0_addr),
    .avs_s0_read       (s0_rd),
    .avs_s0_write      (s0_wr),
    .avs_s0_writedata  (s0_wd),
    .avs_s0_byteenable (s0_be),
    .avs_s0_readdata   (rd0),
    .avs_s0_waitrequest(w0),
    .avs_s1_address    (s1_addr),
    .avs_s1_read       (s1_rd),
    .avs_s1_write      (s1_wr),
    .avs_s1_writedata  (s1_wd),
    .avs_s1_byteenable (s1_be),
    .avs_s1_readdata   (rd1),
    .avs_s1_waitrequest(w1),
    .avm_m0_address    (m_addr),
    .avm_m0_read       (m_rd),
    .avm_m0_write      (m_wr),
    .avm_m0_writedata  (m_wd),
    .avm_m0_byteenable (m_be),
    .avm_m0_readdata   (m_rdata),
    .avm_m0_waitrequest(m_wait),
    .grant             (grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       s0r, s0w, s1r, s1w, mw;
    logic [1:0] eg;
    logic       ew0, ew1;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner    = -1;
    last_srv = 1;
    streak   = 0;
  endtask

  task automatic model_check();
    logic [1:0]    eg;
    logic [AW-1:0] ea;
    logic          erd, ewr, ew0, ew1;
    logic [DW-1:0] ewd;
    logic [1:0]    ebe;
    eg = 2'b00; ea = '0; erd = 1'b0; ewr = 1'b0; ewd = '0; ebe = 2'b00;
    ew0 = 1'b1; ew1 = 1'b1;
    if (owner == 0) begin
      eg = 2'b01; ea = s0_addr; erd = s0_rd; ewr = s0_wr; ewd = s0_wd; ebe = s0_be; ew0 = m_wait;
    end else if (owner == 1) begin
      eg = 2'b10; ea = s1_addr; erd = s1_rd; ewr = s1_wr; ewd = s1_wd; ebe = s1_be; ew1 = m_wait;
    end
    chk("grant", grant, eg);
    chk("m0_address", m_addr, ea);
    chk("m0_read", m_rd, erd);
    chk("m0_write", m_wr, ewr);
    chk("m0_writedata", m_wd, ewd);
    chk("m0_byteenable", m_be, ebe);
    chk("s0_waitrequest", w0, ew0);
    chk("s1_waitrequest", w1, ew1);
    chk("s0_readdata", rd0, m_rdata);
    chk("s1_readdata", rd1, m_rdata);
  endtask

  task automatic model_step();
    bit req[2];
    int o;
    req[0] = s0_rd | s0_wr;
    req[1] = s1_rd | s1_wr;
    if (owner < 0) begin
      if (req[0] && req[1]) owner = 1 - last_srv;
      else if (req[0])      owner = 0;
      else if (req[1])      owner = 1;
    end else begin
      o = 1 - owner;
      if (req[owner] && !m_wait) begin
        if (req[o]) begin
          streak++;
          if (streak >= MH) begin
            last_srv = owner;
            owner    = o;
            streak   = 0;
          end
        end else begin
          streak = 0;
        end
      end else if (!req[owner]) begin
        last_srv = owner;
        owner    = req[o] ? o : -1;
        streak   = 0;
      end
    end
  endtask

  // Called #1 after a negedge with inputs applied; ends on the next negedge.
  task automatic tick();
    model_check();
    model_step();
    @(negedge clk);
  endtask

  task automatic set_req(input logic a, input logic b, input logic c, input logic d, input logic w);
    s0_rd = a; s0_wr = b; s1_rd = c; s1_wr = d; m_wait = w;
  endtask

  initial begin
    tbl = '{
      '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1},
      '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1},
      '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1},
      '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1},
      '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1},
      '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1},
      '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1},
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1}
    };

    rst = 1'b1;
    s0_addr = '0; s1_addr = '0; s0_wd = '0; s1_wd = '0; s0_be = '0; s1_be = '0;
    m_rdata = '0;
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_grant", grant, 2'b00);
    chk("reset_m0_read", m_rd, 1'b0);
    chk("reset_s0_wait", w0, 1'b1);
    chk("reset_s1_wait", w1, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // Vector table: tie-break, MAX_HOLD fairness, stall, withdrawal, last flag.
    for (int i = 0; i < 13; i++) begin
      set_req(tbl[i].s0r, tbl[i].s0w, tbl[i].s1r, tbl[i].s1w, tbl[i].mw);
      s0_addr = 32'h0000_0100 + i; s1_addr = 32'h0000_8000 + i;
      s0_wd = 16'hA000 + 16'(i); s1_wd = 16'h5000 + 16'(i);
      s0_be = 2'b11; s1_be = 2'b01; m_rdata = 16'hC000 + 16'(i);
      #1;
      chk($sformatf("tbl%0d_grant", i), grant, tbl[i].eg);
      chk($sformatf("tbl%0d_s0_wait", i), w0, tbl[i].ew0);
      chk($sformatf("tbl%0d_s1_wait", i), w1, tbl[i].ew1);
      tick();
    end

    // Reset asserted mid-transfer while s1 holds a stalled read.
    set_req(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    #1; tick();
    #1;
    chk("mid_grant_before", grant, 2'b10);
    chk("mid_read_before", m_rd, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_read", m_rd, 1'b0);
    chk("mid_rst_grant", grant, 2'b00);
    chk("mid_rst_s0_wait", w0, 1'b1);
    chk("mid_rst_s1_wait", w1, 1'b1);
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("post_rst_idle_grant", grant, 2'b00);
      tick();
    end

    // Single master read, zero-wait slave.
    s0_addr = 32'h0000_1000; m_rdata = 16'hBEEF;
    set_req(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("single_wait_idle", w0, 1'b1);
    tick();
    #1;
    chk("single_grant", grant, 2'b01);
    chk("single_addr", m_addr, 32'h0000_1000);
    chk("single_read", m_rd, 1'b1);
    chk("single_wait", w0, 1'b0);
    chk("single_rdata", rd0, 16'hBEEF);
    tick();
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1; tick();

    // s1 write stalled 5 cycles with s0 waiting; command must stay stable.
    s1_wd = 16'h1234; s1_be = 2'b10; s1_addr = 32'h0000_2000;
    set_req(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1; tick();
    s0_rd = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_grant", grant, 2'b10);
      chk("stall_wdata", m_wd, 16'h1234);
      chk("stall_be", m_be, 2'b10);
      chk("stall_s0_wait", w0, 1'b1);
      tick();
    end
    m_wait = 1'b0;
    #1;
    chk("stall_done_wait", w1, 1'b0);
    tick();
    s1_wr = 1'b0;
    #1; tick();
    #1;
    chk("stall_switch_grant", grant, 2'b01);
    tick();

    // Random traffic against the reference model.
    for (int n = 0; n < 1500; n++) begin
      s0_rd = ($urandom_range(0, 9) < 5);
      s0_wr = ($urandom_range(0, 9) < 3);
      s1_rd = ($urandom_range(0, 9) < 4);
      s1_wr = ($urandom_range(0, 9) < 3);
      m_wait = ($urandom_range(0, 3) == 0);
      s0_addr = $urandom; s1_addr = $urandom;
      s0_wd = 16'($urandom); s1_wd = 16'($urandom);
      s0_be = 2'($urandom); s1_be = 2'($urandom);
      m_rdata = 16'($urandom);
      #1; tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
